// File: rtl/ice_buffer_arbiter.sv
// Round-robin arbiter that grants one requester at a time a byte path into a shared TX buffer.
// It also reports each finished packet and maintains a shared event-ID counter.
module ice_buffer_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LEN_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   buffer_request,
  output logic [NUM_REQ-1:0]   buffer_grant,
  input  logic [8*NUM_REQ-1:0] buffer_data,
  input  logic [NUM_REQ-1:0]   buffer_valid,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic [NUM_REQ-1:0]   global_counter_inc,
  output logic [7:0]           global_counter,
  output logic                 pkt_done,
  output logic [LEN_W-1:0]     pkt_len,
  output logic [2:0]           pkt_owner,
  output logic                 proto_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_e;

  localparam logic [LEN_W-1:0] LenMax    = '1;
  localparam logic [2:0]       LastReset = 3'(NUM_REQ - 1);

  state_e             r_state, w_state_d;
  logic [2:0]         r_owner, r_last_owner, w_next_owner;
  logic [LEN_W-1:0]   r_cnt;
  logic [7:0]         r_gcnt;
  logic [NUM_REQ-1:0] w_owner_oh, w_sel, w_nonowner;
  logic               w_owner_req, w_owner_inc, w_granted;
  logic [7:0]         w_out_data;

  always_comb begin
    w_owner_oh = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_owner_oh[j] = (r_owner == 3'(j));
    end
  end

  assign w_granted   = (r_state == ST_GRANT);
  assign w_owner_req = |(buffer_request & w_owner_oh);
  assign w_owner_inc = w_granted && |(global_counter_inc & w_owner_oh);
  assign w_sel       = w_granted ? (buffer_valid & w_owner_oh) : '0;
  // Outside a grant nobody owns the path, so every strobe is a violation.
  assign w_nonowner  = w_granted ? ~w_owner_oh : '1;

  // Pick the requester closest after last_owner in circular order.
  always_comb begin
    int d;
    int best;
    d            = 0;
    best         = NUM_REQ;
    w_next_owner = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + NUM_REQ - 1 - int'(r_last_owner)) % NUM_REQ;
      if (buffer_request[j] && d < best) begin
        best         = d;
        w_next_owner = 3'(j);
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  if (|buffer_request) w_state_d = ST_GRANT;
      ST_GRANT: if (!w_owner_req) w_state_d = ST_TURN;
      ST_TURN:  w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= '0;
      r_last_owner <= LastReset;
      r_cnt        <= '0;
      r_gcnt       <= '0;
    end else begin
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
      end else if (out_valid && r_cnt != LenMax) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ST_IDLE && |buffer_request) begin
        r_owner <= w_next_owner;
      end
      if (r_state == ST_TURN) begin
        r_last_owner <= r_owner;
      end
      if (w_owner_inc) begin
        r_gcnt <= r_gcnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_out_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_sel[j]) w_out_data = buffer_data[8*j +: 8];
    end
  end

  assign buffer_grant   = w_granted ? w_owner_oh : '0;
  assign out_valid      = |w_sel;
  assign out_data       = w_out_data;
  assign global_counter = r_gcnt;
  assign pkt_done       = (r_state == ST_TURN);
  assign pkt_len        = (r_state == ST_TURN) ? r_cnt : '0;
  assign pkt_owner      = (r_state == ST_TURN) ? r_owner : 3'd0;
  assign proto_err      = |(buffer_valid & w_nonowner) | |(global_counter_inc & w_nonowner);

endmodule

// File: tb/tb_ice_buffer_arbiter.sv
// Bench for ice_buffer_arbiter: directed scenarios plus random traffic, each cycle compared
// against a holder/finisher reference model of the arbitration rules.
module tb_ice_buffer_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req, grant, valid, inc;
  logic [8*N-1:0] data;
  logic [7:0]     out_data, gcnt;
  logic           out_valid, pkt_done, proto_err;
  logic [LW-1:0]  pkt_len;
  logic [2:0]     pkt_owner;

  ice_buffer_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .buffer_request     (req),
    .buffer_grant       (grant),
    .buffer_data        (data),
    .buffer_valid       (valid),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .global_counter_inc (inc),
    .global_counter     (gcnt),
    .pkt_done           (pkt_done),
    .pkt_len            (pkt_len),
    .pkt_owner          (pkt_owner),
    .proto_err          (proto_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: m_g = requester holding the grant (-1 none), m_f = requester whose packet is
  // being reported this cycle (-1 none); neither set means the arbiter is choosing.
  int m_g, m_f, m_last, m_cnt, m_gcnt;

  logic [N-1:0] obs_grant;
  logic [7:0]   obs_gcnt;
  logic         obs_perr, obs_ov;
  int           done_seen = 0;
  int           last_len, last_owner;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_g = -1; m_f = -1; m_last = N - 1; m_cnt = 0; m_gcnt = 0;
  endtask

  task automatic model_check_step();
    logic [N-1:0] eg;
    logic         ev, ep;
    logic [7:0]   ed;
    int           pick;
    eg = '0; ev = 1'b0; ed = 8'h00; ep = 1'b0;
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      ev = valid[m_g];
      if (ev) ed = data[8*m_g +: 8];
    end
    for (int i = 0; i < N; i++) begin
      if (i != m_g && (valid[i] || inc[i])) ep = 1'b1;
    end
    check_eq("grant", grant, eg);
    check_eq("out_valid", out_valid, ev);
    check_eq("out_data", out_data, ed);
    check_eq("pkt_done", pkt_done, m_f >= 0);
    check_eq("pkt_len", pkt_len, (m_f >= 0) ? m_cnt : 0);
    check_eq("pkt_owner", pkt_owner, (m_f >= 0) ? m_f : 0);
    check_eq("proto_err", proto_err, ep);
    check_eq("global_counter", gcnt, m_gcnt);
    obs_grant = grant; obs_gcnt = gcnt; obs_perr = proto_err; obs_ov = out_valid;
    if (pkt_done) begin
      done_seen++; last_len = int'(pkt_len); last_owner = int'(pkt_owner);
    end
    if (m_g >= 0) begin
      if (ev) m_cnt = (m_cnt + 1 > (1 << LW) - 1) ? (1 << LW) - 1 : m_cnt + 1;
      if (inc[m_g]) m_gcnt = (m_gcnt + 1) % 256;
      if (!req[m_g]) begin
        m_f = m_g; m_g = -1;
      end
    end else if (m_f >= 0) begin
      m_last = m_f; m_f = -1;
    end else begin
      m_cnt = 0;
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && req[(m_last + k) % N]) pick = (m_last + k) % N;
      end
      m_g = pick;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; valid = '0; inc = '0; data = '0;
    model_reset();
    @(negedge clk);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_pkt_done", pkt_done, 0);
    check_eq("rst_pkt_len", pkt_len, 0);
    check_eq("rst_pkt_owner", pkt_owner, 0);
    check_eq("rst_gcnt", gcnt, 0);
    check_eq("rst_proto_err", proto_err, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int order[8];
    int n_order, hold, prev_g, ov_seen, snap;
    logic [N-1:0] pg;

    // Single packet of 11 bytes from requester 0.
    do_reset();
    req = 4'b0001;
    cycle();
    ov_seen = 0;
    for (int k = 0; k < 11; k++) begin
      valid = 4'b0001;
      data[7:0] = (k == 0) ? 8'h62 : 8'(k - 1);
      cycle();
      if (obs_ov) ov_seen++;
    end
    req = '0; valid = '0;
    cycle();
    check_eq("grant_after_drop", obs_grant, 4'b0001);
    cycle();
    check_eq("ov_count32", ov_seen, 11);
    check_eq("len32", last_len, 11);
    check_eq("owner32", last_owner, 0);
    check_eq("done32", done_seen, 1);

    // All four requesting, each holding its grant for 3 cycles.
    do_reset();
    for (int i = 0; i < 8; i++) order[i] = 99;
    n_order = 0; hold = 0; obs_grant = '0;
    for (int c = 0; c < 40; c++) begin
      req = '1;
      if (m_g >= 0 && hold >= 2) req[m_g] = 1'b0;
      prev_g = m_g; pg = obs_grant;
      cycle();
      hold = (m_g >= 0 && m_g == prev_g) ? hold + 1 : 0;
      if (obs_grant != '0 && pg == '0 && n_order < 8) begin
        for (int j = 0; j < N; j++) if (obs_grant[j]) order[n_order] = j;
        n_order++;
      end
    end
    check_eq("rr_0", order[0], 0);
    check_eq("rr_1", order[1], 1);
    check_eq("rr_2", order[2], 2);
    check_eq("rr_3", order[3], 3);
    check_eq("rr_4", order[4], 0);
    req = '0;
    repeat (4) cycle();

    // Event counter wrap with a simultaneous non-owner increment.
    do_reset();
    req = 4'b0001;
    cycle();
    inc = 4'b0001;
    repeat (255) cycle();
    inc = 4'b0011;
    cycle();
    check_eq("gc_ff", obs_gcnt, 8'hFF);
    check_eq("perr34", obs_perr, 1);
    inc = '0;
    cycle();
    check_eq("gc_wrap", obs_gcnt, 8'h00);

    // Non-owner byte strobe is dropped and flagged.
    valid = 4'b0100; data[23:16] = 8'hAA;
    cycle();
    check_eq("ov35", obs_ov, 0);
    check_eq("perr35", obs_perr, 1);
    valid = '0;
    cycle();
    check_eq("perr35_clr", obs_perr, 0);

    // Byte counter saturates at 15.
    for (int k = 0; k < 20; k++) begin
      valid = 4'b0001; data = $urandom;
      cycle();
    end
    valid = '0; req = '0;
    cycle();
    cycle();
    check_eq("len36_sat", last_len, 15);
    check_eq("owner36", last_owner, 0);

    // Asynchronous reset in the middle of a grant.
    req = 4'b0010;
    cycle();
    inc = 4'b0010;
    repeat (3) cycle();
    inc = '0;
    snap = done_seen;
    #1 reset_n = 1'b0;
    #1;
    check_eq("arst_grant", grant, 0);
    check_eq("arst_done", pkt_done, 0);
    check_eq("arst_gcnt", gcnt, 0);
    model_reset();
    #1 reset_n = 1'b1;
    req = 4'b0011;
    cycle();
    cycle();
    check_eq("arst_regrant", obs_grant, 4'b0001);
    req = '0;
    repeat (3) cycle();
    check_eq("arst_done_cnt", done_seen, snap + 1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req = req ^ (N'($urandom) & N'($urandom));
      valid = '0; inc = '0;
      if (m_g >= 0 && $urandom_range(0, 3) != 0) valid[m_g] = 1'b1;
      if (m_g >= 0 && $urandom_range(0, 7) == 0) inc[m_g] = 1'b1;
      if ($urandom_range(0, 15) == 0) valid = valid | N'($urandom);
      if ($urandom_range(0, 15) == 0) inc = inc | N'($urandom);
      data = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
